// File: rtl/led_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// led_pattern_sequencer
//
// Autonomous Avalon-MM master for the 8-bit LED PIO slave (s1). It steps
// through timed LED patterns (rotate-left, bounce, binary count, blink) and
// writes each one to PIO register 0 as a single-cycle write; the PIO has no
// waitrequest, so every access completes in the cycle it is issued.
//
// Optional build macro:
//   READBACK_CHECK_EN - after every pattern write, read register 0 back and
//                       set the sticky error flag on a mismatch. Without it
//                       there are no READ/CHECK states, error is tied low
//                       and pio_readdata is ignored.
//
// Parameters:
//   LED_W      - pattern width, equal to the PIO out_port width (2..32)
//   PRESCALE_W - width of the step period counter
//
// Ports:
//   clk            in   system clock
//   reset_n        in   asynchronous active-low reset
//   enable         in   run request, level-sensitive
//   mode           in   0 rotate-left, 1 bounce, 2 count up, 3 blink
//   period         in   idle cycles between pattern steps, minus one
//   pio_address    out  PIO register address, always 0
//   pio_chipselect out  PIO chipselect
//   pio_write_n    out  PIO write strobe, active low
//   pio_writedata  out  {zeros, pattern}
//   pio_readdata   in   PIO readdata (readback check builds only)
//   busy           out  high whenever the sequencer is not idle
//   pattern        out  working pattern (the one most recently written)
//   error          out  sticky readback mismatch flag
// ---------------------------------------------------------------------------
module led_pattern_sequencer #(
    parameter int LED_W      = 8,
    parameter int PRESCALE_W = 24
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic [PRESCALE_W-1:0] period,
    output logic [1:0]            pio_address,
    output logic                  pio_chipselect,
    output logic                  pio_write_n,
    output logic [31:0]           pio_writedata,
    input  logic [31:0]           pio_readdata,
    output logic                  busy,
    output logic [LED_W-1:0]      pattern,
    output logic                  error
);

    // -----------------------------------------------------------------------
    // Types
    // -----------------------------------------------------------------------
`ifdef READBACK_CHECK_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_COUNT,
        S_BLANK,
        S_READ,
        S_CHECK
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_COUNT,
        S_BLANK
    } state_t;
`endif

    typedef enum logic [1:0] {
        M_ROTATE = 2'd0,
        M_BOUNCE = 2'd1,
        M_COUNT  = 2'd2,
        M_BLINK  = 2'd3
    } mode_t;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t                  r_state;
    mode_t                   r_mode;
    logic                    r_dir_right;   // bounce direction, 0 = moving left
    logic [PRESCALE_W-1:0]   r_cnt;
    logic [LED_W-1:0]        r_pattern;
    logic                    r_cs;
    logic                    r_wr_n;
    logic [31:0]             r_wdata;

    // -----------------------------------------------------------------------
    // Next-state / next-value wires
    // -----------------------------------------------------------------------
    state_t                  w_state_nxt;
    mode_t                   w_mode_nxt;
    mode_t                   w_mode_in;
    logic                    w_dir_right_nxt;
    logic [PRESCALE_W-1:0]   w_cnt_nxt;
    logic [LED_W-1:0]        w_pattern_nxt;
    logic                    w_cs_nxt;
    logic                    w_wr_n_nxt;
    logic [31:0]             w_wdata_nxt;

    logic [LED_W-1:0]        w_adv_pattern;
    logic                    w_adv_dir_right;
    logic [31:0]             w_pattern_ext;

    // Only the low LED_W bits feed the readback compare; the reduction keeps
    // the whole bus formally consumed in every build.
    logic                    w_unused_rdata;
    assign w_unused_rdata = ^pio_readdata;

    assign w_mode_in = mode_t'(mode);

    // -----------------------------------------------------------------------
    // Seed pattern loaded when a mode starts (or is switched to)
    // -----------------------------------------------------------------------
    function automatic logic [LED_W-1:0] f_seed(input mode_t m);
        logic [LED_W-1:0] v;
        v = '0;
        case (m)
            M_ROTATE: v[0] = 1'b1;
            M_BOUNCE: v[0] = 1'b1;
            M_COUNT:  v    = '0;
            M_BLINK:  v    = '1;
            default:  v    = '0;
        endcase
        return v;
    endfunction

    // -----------------------------------------------------------------------
    // One pattern step in the latched mode
    // -----------------------------------------------------------------------
    always_comb begin
        w_adv_pattern   = r_pattern;
        w_adv_dir_right = r_dir_right;
        case (r_mode)
            M_ROTATE: w_adv_pattern = {r_pattern[LED_W-2:0], r_pattern[LED_W-1]};
            M_BOUNCE: begin
                // Direction flips as the lit bit arrives at an end, so the
                // following step already moves back inward.
                if (!r_dir_right) begin
                    w_adv_pattern = r_pattern << 1;
                    if (w_adv_pattern[LED_W-1]) w_adv_dir_right = 1'b1;
                end else begin
                    w_adv_pattern = r_pattern >> 1;
                    if (w_adv_pattern[0]) w_adv_dir_right = 1'b0;
                end
            end
            M_COUNT:  w_adv_pattern = r_pattern + {{(LED_W-1){1'b0}}, 1'b1};
            M_BLINK:  w_adv_pattern = ~r_pattern;
            default:  w_adv_pattern = r_pattern;
        endcase
    end

    always_comb begin
        w_pattern_ext              = '0;
        w_pattern_ext[LED_W-1:0]   = r_pattern;
    end

    // -----------------------------------------------------------------------
    // Readback check (optional)
    // -----------------------------------------------------------------------
`ifdef READBACK_CHECK_EN
    logic r_error;
    logic w_error_nxt;
    assign error = r_error;
`else
    assign error = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // FSM: next state, datapath and bus outputs.
    // Bus outputs are registered, so a strobe decided in a state appears on
    // the bus during the following cycle (first write lands 2 cycles after
    // enable is sampled, steps are period+2 apart).
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_mode_nxt      = r_mode;
        w_dir_right_nxt = r_dir_right;
        w_cnt_nxt       = r_cnt;
        w_pattern_nxt   = r_pattern;
        w_cs_nxt        = 1'b0;
        w_wr_n_nxt      = 1'b1;
        w_wdata_nxt     = r_wdata;
`ifdef READBACK_CHECK_EN
        w_error_nxt     = r_error;
`endif

        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_mode_nxt      = w_mode_in;
                    w_pattern_nxt   = f_seed(w_mode_in);
                    w_dir_right_nxt = 1'b0;
                    w_state_nxt     = S_WRITE;
                end
            end

            S_WRITE: begin
                w_cs_nxt    = 1'b1;
                w_wr_n_nxt  = 1'b0;
                w_wdata_nxt = w_pattern_ext;
                w_cnt_nxt   = period;
`ifdef READBACK_CHECK_EN
                w_state_nxt = S_READ;
`else
                w_state_nxt = S_COUNT;
`endif
            end

`ifdef READBACK_CHECK_EN
            S_READ: begin
                w_cs_nxt    = 1'b1;
                w_wr_n_nxt  = 1'b1;
                w_state_nxt = S_CHECK;
            end

            S_CHECK: begin
                // The read strobe is on the bus during this cycle.
                if (pio_readdata[LED_W-1:0] != r_pattern) w_error_nxt = 1'b1;
                w_cnt_nxt   = period;
                w_state_nxt = S_COUNT;
            end
`endif

            S_COUNT: begin
                if (!enable) begin
                    w_state_nxt = S_BLANK;
                end else if (r_cnt == '0) begin
                    if (w_mode_in != r_mode) begin
                        w_mode_nxt      = w_mode_in;
                        w_pattern_nxt   = f_seed(w_mode_in);
                        w_dir_right_nxt = 1'b0;
                    end else begin
                        w_pattern_nxt   = w_adv_pattern;
                        w_dir_right_nxt = w_adv_dir_right;
                    end
                    w_state_nxt = S_WRITE;
                end else begin
                    w_cnt_nxt = r_cnt - {{(PRESCALE_W-1){1'b0}}, 1'b1};
                end
            end

            S_BLANK: begin
                w_cs_nxt      = 1'b1;
                w_wr_n_nxt    = 1'b0;
                w_wdata_nxt   = '0;
                w_pattern_nxt = '0;
                w_state_nxt   = S_IDLE;
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode      <= M_ROTATE;
            r_dir_right <= 1'b0;
            r_cnt       <= '0;
            r_pattern   <= '0;
            r_cs        <= 1'b0;
            r_wr_n      <= 1'b1;
            r_wdata     <= '0;
        end else begin
            r_mode      <= w_mode_nxt;
            r_dir_right <= w_dir_right_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pattern   <= w_pattern_nxt;
            r_cs        <= w_cs_nxt;
            r_wr_n      <= w_wr_n_nxt;
            r_wdata     <= w_wdata_nxt;
        end
    end

`ifdef READBACK_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_error <= 1'b0;
        end else begin
            r_error <= w_error_nxt;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign pio_address    = 2'b00;
    assign pio_chipselect = r_cs;
    assign pio_write_n    = r_wr_n;
    assign pio_writedata  = r_wdata;
    assign busy           = (r_state != S_IDLE);
    assign pattern        = r_pattern;

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
Autonomous Avalon-MM master that drives the 8-bit LED output PIO slave (s1) without CPU involvement. It generates timed LED patterns (rotate, bounce, binary count, blink) from a programmable prescaler and issues single-cycle PIO register writes at address 0. It sits beside the Nios II data master in the Qsys system; its inputs come from a control register or top-level switches.

Parameters:
LED_W, 8, LED/pattern width; equals the PIO out_port width.
PRESCALE_W, 24, width of the period counter.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  run request; level-sensitive
mode  in  2  0=rotate-left, 1=bounce, 2=binary count up, 3=blink
period  in  PRESCALE_W  idle cycles between pattern steps, minus one
pio_address  out  2  PIO register address; always 0
pio_chipselect  out  1  PIO chipselect
pio_write_n  out  1  PIO write strobe, active low
pio_writedata  out  32  {zeros, pattern[LED_W-1:0]}
pio_readdata  in  32  PIO readdata; used only with READBACK_CHECK_EN
busy  out  1  high in any state other than IDLE
pattern  out  LED_W  last pattern written to the PIO
error  out  1  sticky readback mismatch flag

Behaviour:
- Reset (async, reset_n=0): state IDLE; pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0, busy=0, pattern=0, error=0, counter=0, direction=left. Reset mid-operation aborts any access immediately; no blanking write is issued.
- Access rule: the PIO has no waitrequest. A write is exactly one cycle with chipselect=1, write_n=0. In every other cycle chipselect=0 and write_n=1, except the optional READ cycle.
- States: IDLE, WRITE, COUNT, BLANK (plus READ and CHECK with the macro).
- IDLE: if enable=1, latch mode, load the seed for that mode into pattern, go to WRITE.
- Seeds: rotate=1, bounce=1 with direction=left, count=0, blink=all-ones.
- WRITE: issue the write of the current pattern; load counter with period; go to COUNT.
- COUNT: if enable=0, go to BLANK. Else if counter==0, advance the pattern and go to WRITE. Else decrement the counter.
- Write spacing = period+2 cycles. First write occurs 2 cycles after enable is sampled high in IDLE.
- Pattern advance:
  - rotate: rotate left; MSB wraps to bit 0.
  - bounce: shift in the current direction; reverse on reaching bit LED_W-1 or bit 0. Sequence for LED_W=8: 01,02,…,80,40,…,01,02.
  - count: +1 modulo 2^LED_W; FF wraps to 00.
  - blink: bitwise invert.
- Mode change: sampled only at pattern advance. If mode differs from the latched mode, load the new mode's seed instead of advancing, and latch the new mode.
- Period change: takes effect at the next WRITE.
- BLANK: one write of 0; pattern=0; then IDLE. The enable level is ignored during BLANK, so re-enable is evaluated in IDLE.
- enable=0 in WRITE: the write completes, COUNT is entered, and BLANK follows one cycle later.
- period=0: writes every 2 cycles.

Optional Feature:
READBACK_CHECK_EN defined:
- WRITE goes to READ instead of COUNT.
- READ: chipselect=1, write_n=1, address=0.
- CHECK: compare pio_readdata[LED_W-1:0] to pattern; on mismatch set error=1 (sticky, cleared only by reset); then go to COUNT with counter = period.
- Write spacing becomes period+4. BLANK writes are not checked.
READBACK_CHECK_EN undefined: no READ or CHECK states; error tied 0; pio_readdata ignored.

Test Plan:
- mode=0, period=3, enable=1 at cycle 0 -> writes 01,02,04,…,80,01, one every 5 cycles, first on cycle 2; address=0 on every write.
- mode=1, period=0 -> writedata sequence 01,02,04,08,10,20,40,80,40,20,10,08,04,02,01,02, writes every 2 cycles.
- mode=2, period=1, run 257 steps -> pattern goes FF then 00; busy=1 throughout.
- Mode switch 0->3 while pattern=08 -> next write is FF, then 00, then FF.
- enable dropped mid-COUNT with period=10 -> exactly one write of 00 two cycles later; busy=0 on the next cycle; no further strobes.
- reset_n pulsed low mid-COUNT -> all outputs at reset values asynchronously, with no strobe.
- With READBACK_CHECK_EN, readdata model returns value^1 -> error=1 after the first CHECK and remains 1 after correct reads.
